// File: rtl/ov5640_pkg.sv
// ov5640_pkg: shared types and constants for the OV5640 init sequencer.
//   - init_state_e : sequencer FSM states
//   - SRST_REG     : SCCB register whose bit7 write triggers a sensor soft reset
//   - CNT_W        : width of the wait counters
//   - rom_reg/rom_dat : field slices of a 24-bit init ROM word {reg[15:0], data[7:0]}
package ov5640_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    FETCH,
    LATCH,
    ISSUE,
    WAIT,
    SETTLE,
    NEXT,
    DONE
  } init_state_e;

  localparam logic [15:0] SRST_REG = 16'h3008;
  localparam int          CNT_W    = 20;

  function automatic logic [15:0] rom_reg(input logic [23:0] word);
    return word[23:8];
  endfunction

  function automatic logic [7:0] rom_dat(input logic [23:0] word);
    return word[7:0];
  endfunction

endpackage

// File: rtl/init_delay_cnt.sv
// init_delay_cnt: clearable wait counter shared by the power-up and soft-reset
// settle waits. While en is high it counts up from 0; done pulses in the cycle
// the count equals last, so a wait lasts last+1 cycles from a cleared counter.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (count -> 0)
//   clr        : synchronous clear (takes priority over en)
//   en         : count enable
//   last       : terminal count value
//   done       : high while en is set and the terminal count is reached
module init_delay_cnt
  import ov5640_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] last,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = en && (cnt_q == last);

endmodule

// File: rtl/ov5640_init_sequencer.sv
// ov5640_init_sequencer: walks the OV5640 init ROM and issues one SCCB
// register write per entry, with a power-up wait before the first entry and a
// settle wait after a soft-reset write (0x3008 with data bit7 set).
// Optional build macro: INIT_RETRY_EN -- NACKed writes are reissued up to
// MAX_RETRY times before init_err is set.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   reinit          : pulse; restarts the sequence (no power-up wait) from DONE
//   rom_addr, rom_q : init ROM address / data (1-cycle synchronous read)
//   wr_req, wr_reg, wr_dat : SCCB write request with register address/data
//   wr_ack, wr_done, wr_err: SCCB accept pulse, completion pulse, NACK flag
//   init_done, init_err, busy : status
module ov5640_init_sequencer
  import ov5640_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 24,
  parameter int INIT_NUM      = 86,
  parameter int POWERUP_DELAY = 1_000_000,
  parameter int SRST_DELAY    = 250_000,
  parameter int MAX_RETRY     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reinit,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic                  wr_req,
  output logic [15:0]           wr_reg,
  output logic [7:0]            wr_dat,
  input  logic                  wr_ack,
  input  logic                  wr_done,
  input  logic                  wr_err,
  output logic                  init_done,
  output logic                  init_err,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(INIT_NUM - 1);
  localparam logic [CNT_W-1:0]      PWRUP_LAST = CNT_W'(POWERUP_DELAY - 1);
  localparam logic [CNT_W-1:0]      SRST_LAST  = CNT_W'(SRST_DELAY - 1);

  init_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic                  wr_req_q, wr_req_d;
  logic [15:0]           wr_reg_q, wr_reg_d;
  logic [7:0]            wr_dat_q, wr_dat_d;
  logic                  init_done_q, init_done_d;
  logic                  init_err_q, init_err_d;
  logic                  busy_q, busy_d;

`ifdef INIT_RETRY_EN
  logic [1:0]            retry_q, retry_d;
`else
  logic [1:0]            unused_retry_cfg;
  assign unused_retry_cfg = 2'(MAX_RETRY);
`endif

  // Wait counter: runs only in PWRUP/SETTLE and is held clear elsewhere, so it
  // always starts from 0 on entry to either wait state.
  logic             cnt_en;
  logic             cnt_done;
  logic [CNT_W-1:0] cnt_last;

  assign cnt_en   = (state_q == PWRUP) || (state_q == SETTLE);
  assign cnt_last = (state_q == SETTLE) ? SRST_LAST : PWRUP_LAST;

  init_delay_cnt u_delay_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (!cnt_en || cnt_done),
    .en    (cnt_en),
    .last  (cnt_last),
    .done  (cnt_done)
  );

  // A transaction ends on wr_done in WAIT, or in ISSUE when done coincides with ack.
  logic xfer_end;
  assign xfer_end = wr_done && ((state_q == WAIT) || ((state_q == ISSUE) && wr_ack));

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    wr_req_d    = wr_req_q;
    wr_reg_d    = wr_reg_q;
    wr_dat_d    = wr_dat_q;
    init_done_d = init_done_q;
    init_err_d  = init_err_q;
    busy_d      = busy_q;
`ifdef INIT_RETRY_EN
    retry_d     = retry_q;
`endif

    case (state_q)
      PWRUP:  if (cnt_done) state_d = FETCH;
      FETCH:  state_d = LATCH;
      LATCH: begin
        wr_reg_d = rom_reg(rom_q[23:0]);
        wr_dat_d = rom_dat(rom_q[23:0]);
        wr_req_d = 1'b1;
        state_d  = ISSUE;
      end
      ISSUE: begin
        if (wr_ack) begin
          wr_req_d = 1'b0;
          state_d  = WAIT;
        end
      end
      WAIT:   ;
      SETTLE: if (cnt_done) state_d = NEXT;
      NEXT: begin
`ifdef INIT_RETRY_EN
        retry_d = '0;
`endif
        if (index_q == LAST_IDX) begin
          init_done_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = DONE;
        end else begin
          index_d = index_q + ADDR_WIDTH'(1);
          state_d = FETCH;
        end
      end
      DONE: begin
        if (reinit) begin
          init_done_d = 1'b0;
          init_err_d  = 1'b0;
          busy_d      = 1'b1;
          index_d     = '0;
          state_d     = FETCH;
        end
      end
      default: state_d = PWRUP;
    endcase

    // Completion overrides the ISSUE/WAIT defaults above.
    if (xfer_end) begin
      if (wr_err) begin
`ifdef INIT_RETRY_EN
        if (retry_q != 2'(MAX_RETRY)) begin
          retry_d  = retry_q + 2'd1;
          wr_req_d = 1'b1;
          state_d  = ISSUE;
        end else begin
          init_err_d = 1'b1;
          state_d    = NEXT;
        end
`else
        init_err_d = 1'b1;
        state_d    = NEXT;
`endif
      end else if ((wr_reg_q == SRST_REG) && wr_dat_q[7]) begin
        state_d = SETTLE;
      end else begin
        state_d = NEXT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= PWRUP;
      index_q     <= '0;
      wr_req_q    <= 1'b0;
      wr_reg_q    <= '0;
      wr_dat_q    <= '0;
      init_done_q <= 1'b0;
      init_err_q  <= 1'b0;
      busy_q      <= 1'b1;
`ifdef INIT_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      wr_req_q    <= wr_req_d;
      wr_reg_q    <= wr_reg_d;
      wr_dat_q    <= wr_dat_d;
      init_done_q <= init_done_d;
      init_err_q  <= init_err_d;
      busy_q      <= busy_d;
`ifdef INIT_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  // The ROM address is the entry index itself; it only changes in NEXT/DONE,
  // so it is stable through FETCH and LATCH.
  assign rom_addr  = index_q;
  assign wr_req    = wr_req_q;
  assign wr_reg    = wr_reg_q;
  assign wr_dat    = wr_dat_q;
  assign init_done = init_done_q;
  assign init_err  = init_err_q;
  assign busy      = busy_q;

endmodule
